sevenseg_scan_ctl: RTL and testbench

// Time-multiplexed scan controller for the 8-digit common-anode seven-segment display on the Nexys A7.
// - Cycles through the digits one slot at a time.
// - Per slot, presents that digit's hex code to the downstream hex-to-segment decoder and drives the

---
 rtl/sevenseg_scan_ctl.sv | 96 +++++++++
 tb/tb_sevenseg_scan_ctl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctl.sv
// rtl/sevenseg_scan_ctl.sv - multiplexed seven-segment scan controller
// Double-buffered load port; new contents become active only on a frame wrap.
module sevenseg_scan_ctl #(
   parameter int NDIGITS  = 8,
   parameter int TICK_DIV = 100000,
   parameter int DEAD     = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_valid,
   output logic                   load_ready,
   input  logic [4*NDIGITS-1:0]   load_data,
   input  logic [NDIGITS-1:0]     load_blank,
   input  logic [NDIGITS-1:0]     load_dp,
   output logic [6:0]             digit_code,
   output logic [NDIGITS-1:0]     an_n,
   output logic                   dp_n,
   output logic                   frame_start
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int IDX_W = $clog2(NDIGITS);

   logic [CNT_W-1:0]       cnt;
   logic [IDX_W-1:0]       idx;
   logic [4*NDIGITS-1:0]   act_data;
   logic [NDIGITS-1:0]     act_blank;
   logic [NDIGITS-1:0]     act_dp;
   logic [4*NDIGITS-1:0]   pend_data;
   logic [NDIGITS-1:0]     pend_blank;
   logic [NDIGITS-1:0]     pend_dp;
   logic                   wrap_d;

   logic                   slot_end;
   logic                   frame_wrap;
   logic                   accept;
   logic                   anode_on;
   logic [3:0]             nibble;
   logic [NDIGITS-1:0]     an_next;

   assign slot_end   = (cnt == CNT_W'(TICK_DIV - 1));
   assign frame_wrap = slot_end && (idx == IDX_W'(NDIGITS - 1));
   assign accept     = load_valid && load_ready;
   assign nibble     = act_data[{idx, 2'b00} +: 4];
   assign anode_on   = (cnt >= CNT_W'(DEAD)) && !act_blank[idx];

   always_comb begin
      an_next = '1;
      if (anode_on)
         an_next[idx] = 1'b0;
   end

   // load_ready doubles as the "pending buffer empty" flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         idx         <= '0;
         act_data    <= '0;
         act_blank   <= '1;
         act_dp      <= '0;
         pend_data   <= '0;
         pend_blank  <= '0;
         pend_dp     <= '0;
         load_ready  <= 1'b1;
         wrap_d      <= 1'b0;
         an_n        <= '1;
         digit_code  <= '0;
         dp_n        <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         cnt <= slot_end ? '0 : cnt + 1'b1;
         if (slot_end)
            idx <= (idx == IDX_W'(NDIGITS - 1)) ? '0 : idx + 1'b1;
         wrap_d <= frame_wrap;

         if (frame_wrap && !load_ready) begin
            act_data   <= pend_data;
            act_blank  <= pend_blank;
            act_dp     <= pend_dp;
            load_ready <= 1'b1;
         end else if (accept) begin
            pend_data  <= load_data;
            pend_blank <= load_blank;
            pend_dp    <= load_dp;
            load_ready <= 1'b0;
         end

         // outputs lag the scan state by one cycle so the wrap pulse lines up with slot 0
         an_n        <= an_next;
         digit_code  <= {3'b000, nibble};
         dp_n        <= anode_on ? ~act_dp[idx] : 1'b1;
         frame_start <= wrap_d;
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_ctl.sv
// tb/tb_sevenseg_scan_ctl.sv - self-checking bench for sevenseg_scan_ctl
// Reference model derives the display from the cycle number and a commit schedule.
module tb_sevenseg_scan_ctl;

   localparam int ND = 8;
   localparam int TD = 8;
   localparam int DD = 2;
   localparam int FR = ND * TD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [31:0] load_data = '0;
   logic [7:0]  load_blank = '0;
   logic [7:0]  load_dp = '0;
   logic [6:0]  digit_code;
   logic [7:0]  an_n;
   logic        dp_n;
   logic        frame_start;

   sevenseg_scan_ctl #(.NDIGITS(ND), .TICK_DIV(TD), .DEAD(DD)) dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .load_blank(load_blank), .load_dp(load_dp),
      .digit_code(digit_code), .an_n(an_n), .dp_n(dp_n), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] d;
      logic [7:0]  b;
      logic [7:0]  p;
   } disp_t;

   disp_t src_q[$];
   int    total = 0;
   int    bad = 0;
   int    t;
   disp_t m_act, m_prev, m_pend;
   bit    m_pending, m_acc;

   function automatic disp_t rand_disp();
      disp_t r;
      r.d = $urandom;
      r.b = 8'($urandom) & 8'($urandom);
      r.p = 8'($urandom);
      return r;
   endfunction

   function automatic logic [17:0] obs();
      return {an_n, digit_code, dp_n, frame_start, load_ready};
   endfunction

   // expected outputs after t edges: they show the scan position and contents of edge t-1
   function automatic logic [17:0] exp_vec();
      int s, c, i;
      logic [7:0] an;
      logic on, dpn, fs;
      logic [6:0] dc;
      if (t == 0) return {8'hFF, 7'h00, 1'b1, 1'b0, 1'b1};
      s  = t - 1;
      c  = s % TD;
      i  = (s / TD) % ND;
      on = (c >= DD) && !m_prev.b[i];
      an = 8'hFF;
      if (on) an[i] = 1'b0;
      dc  = {3'b000, m_prev.d[4*i +: 4]};
      dpn = on ? ~m_prev.p[i] : 1'b1;
      fs  = (s > 0) && (s % FR == 0);
      return {an, dc, dpn, fs, !m_pending};
   endfunction

   task automatic drive();
      if (src_q.size() > 0) begin
         load_valid = 1'b1;
         load_data  = src_q[0].d;
         load_blank = src_q[0].b;
         load_dp    = src_q[0].p;
      end else begin
         load_valid = 1'b0;
         load_data  = $urandom;
         load_blank = 8'($urandom);
         load_dp    = 8'($urandom);
      end
   endtask

   task automatic model_reset();
      t = 0;
      m_act = '{d: 32'h0, b: 8'hFF, p: 8'h00};
      m_prev = m_act;
      m_pend = m_act;
      m_pending = 0;
      m_acc = 0;
      src_q.delete();
   endtask

   task automatic step();
      @(posedge clk);
      m_acc  = load_valid && !m_pending;
      m_prev = m_act;
      if (((t + 1) % FR == 0) && m_pending) begin
         m_act = m_pend;
         m_pending = 0;
      end
      if (m_acc) begin
         m_pend = src_q.pop_front();
         m_pending = 1;
      end
      t++;
      @(negedge clk);
      drive();
   endtask

   task automatic test_reset();
      model_reset();
      drive();
      repeat (3) @(negedge clk);
      total++; if (an_n !== 8'hFF) begin bad++; $display("FAIL reset_an got=%h want=ff", an_n); end
      total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b want=1", dp_n); end
      total++; if (digit_code !== 7'h00) begin bad++; $display("FAIL reset_code got=%h want=00", digit_code); end
      total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", load_ready); end
      total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b want=0", frame_start); end
      rst = 1'b0;
      for (int k = 0; k < FR + 10; k++) begin
         step();
         total++;
         if (obs() !== exp_vec()) begin bad++; $display("FAIL reset_idle t=%0d got=%h want=%h", t, obs(), exp_vec()); end
      end
   endtask

   task automatic test_load();
      bit acc_seen = 0, found = 0;
      int slot;
      src_q.push_back('{d: 32'h12345678, b: 8'h00, p: 8'h01});
      drive();
      for (int k = 0; k < 200 && !found; k++) begin
         step();
         total++;
         if (obs() !== exp_vec()) begin bad++; $display("FAIL load_wait t=%0d got=%h want=%h", t, obs(), exp_vec()); end
         if (acc_seen && frame_start === 1'b1) found = 1;
         if (m_acc) acc_seen = 1;
      end
      total++;
      if (!found) begin bad++; $display("FAIL load_commit got=no_frame_start want=frame_start"); end
      for (int k = 0; k < FR; k++) begin
         slot = k / TD;
         total++;
         if (frame_start !== (k == 0)) begin bad++; $display("FAIL load_fs k=%0d got=%b want=%b", k, frame_start, (k == 0)); end
         total++;
         if (digit_code !== 7'(8 - slot)) begin bad++; $display("FAIL load_code k=%0d got=%h want=%h", k, digit_code, 7'(8 - slot)); end
         total++;
         if (an_n !== ((k % TD < DD) ? 8'hFF : ~(8'h01 << slot))) begin
            bad++; $display("FAIL load_an k=%0d got=%h want=%h", k, an_n, (k % TD < DD) ? 8'hFF : ~(8'h01 << slot));
         end
         total++;
         if (dp_n !== !(slot == 0 && k % TD >= DD)) begin bad++; $display("FAIL load_dp k=%0d got=%b", k, dp_n); end
         step();
         total++;
         if (obs() !== exp_vec()) begin bad++; $display("FAIL load_scan t=%0d got=%h want=%h", t, obs(), exp_vec()); end
      end
   endtask

   task automatic test_back_to_back();
      int w = $urandom_range(40, 5);
      for (int k = 0; k < w; k++) begin
         step();
         total++;
         if (obs() !== exp_vec()) begin bad++; $display("FAIL b2b_pre t=%0d got=%h want=%h", t, obs(), exp_vec()); end
      end
      src_q.push_back(rand_disp());
      src_q.push_back(rand_disp());
      drive();
      for (int k = 0; k < 3 * FR + 10; k++) begin
         step();
         total++;
         if (obs() !== exp_vec()) begin bad++; $display("FAIL b2b_scan t=%0d got=%h want=%h", t, obs(), exp_vec()); end
      end
      total++;
      if (src_q.size() != 0) begin bad++; $display("FAIL b2b_drain got=%0d want=0", src_q.size()); end
   endtask

   task automatic test_blank();
      disp_t v = rand_disp();
      bit acc_seen = 0, found = 0;
      v.b = 8'hF0;
      src_q.push_back(v);
      drive();
      for (int k = 0; k < 200 && !found; k++) begin
         step();
         total++;
         if (obs() !== exp_vec()) begin bad++; $display("FAIL blank_wait t=%0d got=%h want=%h", t, obs(), exp_vec()); end
         if (acc_seen && frame_start === 1'b1) found = 1;
         if (m_acc) acc_seen = 1;
      end
      total++;
      if (!found) begin bad++; $display("FAIL blank_commit got=no_frame_start want=frame_start"); end
      for (int k = 0; k < FR; k++) begin
         total++;
         if (an_n[7:4] !== 4'hF) begin bad++; $display("FAIL blank_an k=%0d got=%h want=f", k, an_n[7:4]); end
         if (k / TD >= 4) begin
            total++;
            if (dp_n !== 1'b1) begin bad++; $display("FAIL blank_dp k=%0d got=%b want=1", k, dp_n); end
         end
         step();
         total++;
         if (obs() !== exp_vec()) begin bad++; $display("FAIL blank_scan t=%0d got=%h want=%h", t, obs(), exp_vec()); end
      end
   endtask

   task automatic test_wrap_accept();
      disp_t old_v, new_v;
      for (int k = 0; k < 300 && (m_pending || src_q.size() > 0 || (t % FR) != FR - 1); k++) begin
         step();
         total++;
         if (obs() !== exp_vec()) begin bad++; $display("FAIL wrap_pre t=%0d got=%h want=%h", t, obs(), exp_vec()); end
      end
      old_v = m_act;
      new_v = rand_disp();
      new_v.d[3:0] = old_v.d[3:0] ^ 4'h5;
      src_q.push_back(new_v);
      drive();
      step();
      total++;
      if (load_ready !== 1'b0) begin bad++; $display("FAIL wrap_ready got=%b want=0", load_ready); end
      step();
      total++;
      if (frame_start !== 1'b1 || digit_code !== {3'b000, old_v.d[3:0]}) begin
         bad++; $display("FAIL wrap_old fs=%b code=%h want fs=1 code=%h", frame_start, digit_code, old_v.d[3:0]);
      end
      for (int k = 0; k < FR; k++) begin
         step();
         total++;
         if (obs() !== exp_vec()) begin bad++; $display("FAIL wrap_scan t=%0d got=%h want=%h", t, obs(), exp_vec()); end
      end
      total++;
      if (frame_start !== 1'b1 || digit_code !== {3'b000, new_v.d[3:0]}) begin
         bad++; $display("FAIL wrap_new fs=%b code=%h want fs=1 code=%h", frame_start, digit_code, new_v.d[3:0]);
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 300 && (m_pending || src_q.size() > 0 || (t % FR) != 10); k++) begin
         step();
         total++;
         if (obs() !== exp_vec()) begin bad++; $display("FAIL rmid_pre t=%0d got=%h want=%h", t, obs(), exp_vec()); end
      end
      src_q.push_back(rand_disp());
      drive();
      for (int k = 0; k < 100 && (t % FR) != 3 * TD + 5; k++) begin
         step();
         total++;
         if (obs() !== exp_vec()) begin bad++; $display("FAIL rmid_run t=%0d got=%h want=%h", t, obs(), exp_vec()); end
      end
      rst = 1'b1;
      #1;
      total++; if (an_n !== 8'hFF) begin bad++; $display("FAIL rmid_an got=%h want=ff", an_n); end
      total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", load_ready); end
      total++; if (digit_code !== 7'h00 || dp_n !== 1'b1) begin bad++; $display("FAIL rmid_out code=%h dp=%b want 00/1", digit_code, dp_n); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      drive();
      for (int k = 0; k < 2 * FR + 3; k++) begin
         step();
         total++;
         if (an_n !== 8'hFF) begin bad++; $display("FAIL rmid_dark t=%0d got=%h want=ff", t, an_n); end
         total++;
         if (obs() !== exp_vec()) begin bad++; $display("FAIL rmid_scan t=%0d got=%h want=%h", t, obs(), exp_vec()); end
      end
      src_q.push_back(rand_disp());
      drive();
      for (int k = 0; k < 2 * FR + 5; k++) begin
         step();
         total++;
         if (obs() !== exp_vec()) begin bad++; $display("FAIL rmid_reload t=%0d got=%h want=%h", t, obs(), exp_vec()); end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_back_to_back();
      test_blank();
      test_wrap_accept();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
